// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared widths, select-width helper and per-channel state record for multi_clock_gen.
package clkgen_pkg;
  localparam int CW_DEF = 32;
  localparam int CW_MAX = 32;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  typedef struct packed {
    logic [CW_MAX-1:0] cnt;
    logic [CW_MAX-1:0] half_hi;
    logic [CW_MAX-1:0] half_lo;
    logic [CW_MAX-1:0] pend_hi;
    logic [CW_MAX-1:0] pend_lo;
    logic              pend_vld;
    logic              lvl;
  } chan_st_t;
endpackage

// File: rtl/clkgen_chan.sv
// clkgen_chan: one divider channel with pending half-period registers applied at the next toggle.
module clkgen_chan
  import clkgen_pkg::*;
#(
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] DEF_HALF = CW'(1),
  parameter logic          CLK_INIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] hi,
  input  logic [CW-1:0] lo,
  output logic          clk_out,
  output logic          tick
);
  chan_st_t s, s_n;
  logic tick_n, done;
  logic [CW_MAX-1:0] w_hi, w_lo, cur;
  always_comb begin
    w_hi = (hi == '0) ? CW_MAX'(1) : CW_MAX'(hi);
    w_lo = (lo == '0) ? CW_MAX'(1) : CW_MAX'(lo);
    cur = s.lvl ? s.half_hi : s.half_lo;
    done = s.cnt >= cur - CW_MAX'(1);
    s_n = s;
    tick_n = 1'b0;
    if (sync) begin
      s_n.cnt = '0;
      s_n.lvl = CLK_INIT;
      s_n.half_hi = wr ? w_hi : s.pend_vld ? s.pend_hi : s.half_hi;
      s_n.half_lo = wr ? w_lo : s.pend_vld ? s.pend_lo : s.half_lo;
      s_n.pend_vld = 1'b0;
    end else begin
      if (en) begin
        s_n.cnt = done ? '0 : s.cnt + CW_MAX'(1);
        s_n.lvl = s.lvl ^ done;
        tick_n = done & ~s.lvl;
      end
      // frozen channels take a pending value at once and restart their half
      if (s.pend_vld && (done || !en)) begin
        s_n.half_hi = s.pend_hi;
        s_n.half_lo = s.pend_lo;
        s_n.pend_vld = 1'b0;
        s_n.cnt = '0;
      end
      if (wr) begin
        s_n.pend_hi = w_hi;
        s_n.pend_lo = w_lo;
        s_n.pend_vld = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '{cnt: '0, half_hi: CW_MAX'(DEF_HALF), half_lo: CW_MAX'(DEF_HALF),
             pend_hi: CW_MAX'(DEF_HALF), pend_lo: CW_MAX'(DEF_HALF), pend_vld: 1'b0, lvl: CLK_INIT};
      tick <= 1'b0;
    end else begin
      s <= s_n;
      tick <= tick_n;
    end
  end
  assign clk_out = s.lvl;
endmodule

// File: rtl/multi_clock_gen.sv
// multi_clock_gen: CH programmable clock/tick channels with write decode and shared sync.
// Define CLKGEN_DUTY_EN for separate high/low half-periods (adds the div_lo port).
module multi_clock_gen
  import clkgen_pkg::*;
#(
  parameter int            CLK_HZ   = 27_000_000,
  parameter int            CH       = 4,
  parameter int            CW       = CW_DEF,
  parameter logic [CW-1:0] DEF_HALF = CW'(CLK_HZ / 20),
  parameter logic          CLK_INIT = 1'b1,
  localparam int           SW       = clog2_min1(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          div_wr,
  input  logic [SW-1:0] div_sel,
  input  logic [CW-1:0] div_val,
`ifdef CLKGEN_DUTY_EN
  input  logic [CW-1:0] div_lo,
`endif
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick
);
  logic [CW-1:0] lo_val;
`ifdef CLKGEN_DUTY_EN
  assign lo_val = div_lo;
`else
  assign lo_val = div_val;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    clkgen_chan #(.CW(CW), .DEF_HALF(DEF_HALF), .CLK_INIT(CLK_INIT)) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (div_wr && div_sel == SW'(i)),
      .hi      (div_val),
      .lo      (lo_val),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end
endmodule

// File: tb/tb_multi_clock_gen.sv
// tb_multi_clock_gen: directed and random stimulus against a countdown reference model.
module tb_multi_clock_gen;
  logic       clk = 1'b0, rst = 1'b1, sync = 1'b0, div_wr = 1'b0;
  logic [3:0] en = '0, clk_out, tick;
  logic [1:0] div_sel = '0;
  logic [7:0] div_val = '0;
`ifdef CLKGEN_DUTY_EN
  logic [7:0] div_lo = '0;
`endif
  int n_asr = 0, n_fail = 0;
  int rem[4], hi[4], lo[4], ph[4], pl[4];
  bit pv[4];
  logic [3:0] m_lvl, m_tick;

  multi_clock_gen #(.CLK_HZ(60), .CH(4), .CW(8), .DEF_HALF(8'd3), .CLK_INIT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr), .div_sel(div_sel), .div_val(div_val),
`ifdef CLKGEN_DUTY_EN
    .div_lo(div_lo),
`endif
    .clk_out(clk_out), .tick(tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_lvl = 4'hF;
    m_tick = '0;
    for (int i = 0; i < 4; i++) begin
      hi[i] = 3; lo[i] = 3; ph[i] = 3; pl[i] = 3; pv[i] = 0; rem[i] = 3;
    end
  endtask

  // Each channel is a countdown of cycles left in its current half.
  task automatic m_clock();
    int wh, wl;
    bit w, tog;
    wh = (div_val == 0) ? 1 : int'(div_val);
`ifdef CLKGEN_DUTY_EN
    wl = (div_lo == 0) ? 1 : int'(div_lo);
`else
    wl = wh;
`endif
    for (int i = 0; i < 4; i++) begin
      w = div_wr && (int'(div_sel) == i);
      m_tick[i] = 1'b0;
      if (sync) begin
        m_lvl[i] = 1'b1;
        if (w) begin hi[i] = wh; lo[i] = wl; end
        else if (pv[i]) begin hi[i] = ph[i]; lo[i] = pl[i]; end
        pv[i] = 0;
        rem[i] = hi[i];
      end else begin
        tog = 0;
        if (en[i]) begin
          rem[i]--;
          tog = (rem[i] <= 0);
        end
        if (tog) begin
          m_lvl[i] = ~m_lvl[i];
          m_tick[i] = m_lvl[i];
        end
        if (pv[i] && (tog || !en[i])) begin
          hi[i] = ph[i]; lo[i] = pl[i]; pv[i] = 0; tog = 1;
        end
        if (tog) rem[i] = m_lvl[i] ? hi[i] : lo[i];
        if (w) begin ph[i] = wh; pl[i] = wl; pv[i] = 1; end
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) m_reset(); else m_clock();
    @(negedge clk);
    chk({tag, ".clk_out"}, clk_out, m_lvl);
    chk({tag, ".tick"}, tick, m_tick);
  endtask

  initial begin
    logic [3:0] held;
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset.clk_out", clk_out, 4'hF);
    chk("reset.tick", tick, 4'h0);
    rst = 1'b0;
    en = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      step("t1");
      if (c == 3) chk("t1.fall3", clk_out, 4'h0);
      if (c == 6) chk("t1.rise6", tick, 4'hF);
      if (c == 5) chk("t1.notick5", tick, 4'h0);
    end
    step("t2.pre");
    div_wr = 1'b1; div_sel = 2'd2; div_val = 8'd5;
    step("t2.wr");
    div_wr = 1'b0;
    repeat (25) step("t2");
    div_wr = 1'b1; div_sel = 2'd1; div_val = 8'd0;
    step("t3.wr");
    div_wr = 1'b0;
    repeat (3) step("t3");
    for (int c = 0; c < 8; c++) begin
      held = clk_out;
      step("t3.run");
      chk("t3.toggle", {3'b0, clk_out[1]}, {3'b0, ~held[1]});
    end
    en[0] = 1'b0;
    held = clk_out;
    for (int c = 0; c < 10; c++) begin
      step("t4.frozen");
      chk("t4.hold", {3'b0, clk_out[0]}, {3'b0, held[0]});
    end
    en[0] = 1'b1;
    repeat (8) step("t4.resume");
    sync = 1'b1; div_wr = 1'b1; div_sel = 2'd3; div_val = 8'd7;
    step("t5.sync");
    chk("t5.all_high", clk_out, 4'hF);
    sync = 1'b0; div_wr = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step("t5");
      if (c == 3) chk("t5.ch3_high", {3'b0, clk_out[3]}, 4'h1);
      if (c == 7) chk("t5.ch3_low", {3'b0, clk_out[3]}, 4'h0);
    end
    #2 rst = 1'b1;
    #1 chk("t6.async.clk_out", clk_out, 4'hF);
    chk("t6.async.tick", tick, 4'h0);
    step("t6.held");
    rst = 1'b0;
    repeat (6) step("t6.after");
`ifdef CLKGEN_DUTY_EN
    div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd2; div_lo = 8'd6;
    step("t6.duty.wr");
    div_wr = 1'b0;
    repeat (24) step("t6.duty");
`endif
    for (int c = 0; c < 400; c++) begin
      en = 4'($urandom) | 4'($urandom);
      sync = ($urandom_range(0, 39) == 0);
      div_wr = ($urandom_range(0, 5) == 0);
      div_sel = 2'($urandom);
      div_val = 8'($urandom_range(0, 6));
`ifdef CLKGEN_DUTY_EN
      div_lo = 8'($urandom_range(0, 6));
`endif
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end
endmodule
